pll_rst_seq: RTL
================

# pll_rst_seq

Reset sequencer downstream of the PLL wrapper: runs on the free-running reference clock (the same clock as the PLL's `mdclk`) and drives the PLL wrapper's `reset` input. It monitors the wrapper's `lock` output and releases the system reset only after lock has been continuously stable. On lock loss or lock timeout it re-resets the PLL, and it counts failures for status readout.

## Interface
- `RST_HOLD_CYCLES`, 64: cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum wait for lock after `pll_reset` drops (≥1).
- `clk` in 1: free-running reference clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_lock` in 1: PLL wrapper `lock`; asynchronous to `clk`.
- `restart` in 1: single-cycle request to re-run the full sequence.
- `pll_reset` out 1: active-high to PLL wrapper `reset`.
- `sys_rst_n` out 1: active-low system reset for PLL-clocked logic.
- `ready` out 1: high only in RUN.
- `fail_cnt` out 8: saturating count of timeouts and lock losses in RUN.

## Operation
- `pll_lock` passes through a 2-FF synchronizer to give `lock_s`. All decisions use `lock_s` only.
- A single counter `cnt` is cleared on every state change. Width = clog2(max of the three parameters)+1.
- States and transitions:
  - RESET_PLL: `pll_reset`=1. After `RST_HOLD_CYCLES` cycles in this state → WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0.
    - `lock_s`=1 → STABLE.
    - `cnt` reaches `LOCK_TIMEOUT_CYCLES` → RESET_PLL and `fail_cnt`++.
  - STABLE:
    - `lock_s`=0 → WAIT_LOCK. This does not count as a failure; the timeout restarts from 0.
    - `LOCK_STABLE_CYCLES` consecutive cycles with `lock_s`=1 → RUN.
  - RUN: `sys_rst_n`=1 and `ready`=1.
    - `lock_s`=0 → RESET_PLL and `fail_cnt`++.
- `restart`=1 in any state → RESET_PLL with `cnt` cleared. `fail_cnt` is not incremented.
- Precedence: `restart` > lock-loss/timeout > normal progression.
- `fail_cnt` saturates at 255. It is cleared only by `rst_n`.
- `sys_rst_n`=0 and `ready`=0 in every state other than RUN.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=RESET_PLL, `cnt`=0, synchronizer flops=0.
  - `pll_reset`=1, `sys_rst_n`=0, `ready`=0, `fail_cnt`=0.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Startup: the first edge with `rst_n`=1 is cycle 0. `pll_reset` is high for cycles 0..`RST_HOLD_CYCLES`-1 and low from cycle `RST_HOLD_CYCLES`.
- Lock acquisition: let E be the first edge that samples `pll_lock`=1 while in WAIT_LOCK.
  - STABLE is entered at E+2.
  - `sys_rst_n` and `ready` rise at E+2+`LOCK_STABLE_CYCLES`, provided lock stays high.
- Lock loss in RUN: `sys_rst_n` falls and `pll_reset` rises 2 edges after the edge that first samples `pll_lock`=0, i.e. one cycle after `lock_s` falls.
- Timeout: `pll_reset` rises exactly `LOCK_TIMEOUT_CYCLES` edges after entering WAIT_LOCK with no `lock_s`.
- Simultaneous events:
  - `restart` together with lock loss: `fail_cnt` unchanged.
  - `lock_s` rising on the same edge the timeout is reached: timeout wins.
- A `pll_lock` glitch shorter than one `clk` period may be missed. That is acceptable.

## Structure
- Package `pll_rst_pkg`:
  - state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN);
  - `FAIL_CNT_W`=8;
  - counter-width helper function.
- Sub-module `sync_2ff`: a generic 2-flop bit synchronizer with synchronous active-low reset to 0, instantiated for `pll_lock`.
- The top holds the FSM, `cnt` and `fail_cnt`. Expected size is about 150 lines.

## Test plan
Bench parameters: `RST_HOLD_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.

- Clean start:
  - Stimulus: release `rst_n`; raise `pll_lock` at cycle 10 (E=10).
  - Required: `pll_reset` high during cycles 0–3; `sys_rst_n` and `ready` high from cycle 20; `fail_cnt`=0.
- Lock timeout:
  - Stimulus: never raise `pll_lock`.
  - Required: `pll_reset` re-rises at cycle 36 (4 hold + 32 wait); `fail_cnt`=1 at cycle 36 and 2 at cycle 72.
- Chatter during STABLE:
  - Stimulus: `pll_lock` high 5 cycles, low 1, then high.
  - Required: no `fail_cnt` change; `sys_rst_n` rises 10 cycles (2 sync + 8 stable) after the second rising-edge sample.
- Lock loss in RUN:
  - Stimulus: drop `pll_lock` once `ready`=1.
  - Required: `sys_rst_n`=0 and `pll_reset`=1 two edges later; `fail_cnt`=1; full re-sequence follows.
- Restart:
  - Stimulus: pulse `restart` in RUN and, separately, in WAIT_LOCK.
  - Required: RESET_PLL on the next edge; `pll_reset` held 4 cycles; `fail_cnt` unchanged.
- Saturation and reset mid-operation:
  - Stimulus: force 300 timeouts; then assert `rst_n`=0 in STABLE.
  - Required: `fail_cnt` holds at 255; after reset, `fail_cnt`=0, `pll_reset`=1, `ready`=0.

Source files
------------

// File: rtl/pll_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_pkg
// Description : Shared types and helpers for the PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int FAIL_CNT_W = 8;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop single-bit synchronizer, synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_seq
// Description : Holds the PLL in reset, waits for stable lock, then releases
//               the system reset; re-sequences on lock loss or lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  restart,
    output logic                  pll_reset,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic [FAIL_CNT_W-1:0] fail_cnt
);

    localparam int c_cnt_w = cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FAIL_CNT_W-1:0] c_fail_max  = {FAIL_CNT_W{1'b1}};

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [FAIL_CNT_W-1:0]   r_fail_cnt;
    logic                    r_armed;
    logic                    r_pll_reset;
    logic                    r_sys_rst_n;
    logic                    r_ready;
    logic                    w_lock_s;
    logic                    w_fail_evt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    // Timeout is checked ahead of lock so a coincident lock_s rise still fails.
    always_comb begin
        w_state_nxt = r_state;
        w_fail_evt  = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_armed && (r_cnt == c_hold_last)) w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (r_cnt == c_timeout_last) begin
                    w_state_nxt = RESET_PLL;
                    w_fail_evt  = 1'b1;
                end else if (w_lock_s) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (!w_lock_s)                    w_state_nxt = WAIT_LOCK;
                else if (r_cnt == c_stable_last)  w_state_nxt = RUN;
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = RESET_PLL;
                    w_fail_evt  = 1'b1;
                end
            end
            default: w_state_nxt = RESET_PLL;
        endcase
        if (restart) begin
            w_state_nxt = RESET_PLL;
            w_fail_evt  = 1'b0;
        end
    end

    // r_armed makes the first edge after reset release the first counted
    // cycle of the hold, so pll_reset drops exactly RST_HOLD_CYCLES edges later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RESET_PLL;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_fail_cnt  <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            if (restart || (w_state_nxt != r_state)) begin
                r_cnt <= '0;
            end else if (r_armed && (r_state != RUN)) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_fail_evt && (r_fail_cnt != c_fail_max)) begin
                r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
            end
            r_pll_reset <= (w_state_nxt == RESET_PLL);
            r_sys_rst_n <= (w_state_nxt == RUN);
            r_ready     <= (w_state_nxt == RUN);
        end
    end

    assign pll_reset = r_pll_reset;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign fail_cnt  = r_fail_cnt;

endmodule
`default_nettype wire
